// File: rtl/permuter_rr_scheduler.sv
// -----------------------------------------------------------------------------
// permuter_rr_scheduler
//   Shares one registered 4-lane permuter among NREQ requesters. A round-robin
//   arbiter grants one request at a time. The winning lane data and control
//   word are held on the permuter inputs. The permuted result is returned on a
//   single response channel, tagged with the id of the winning requester.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   req_valid      per-requester request valid
//   req_ready      per-requester accept; one-hot or zero, only asserted in IDLE
//   req_din        request lane data, slice i belongs to requester i
//   req_control    2-bit permutation select, slice i belongs to requester i
//   perm_din       lane data driven to the permuter (held between transactions)
//   perm_control   control word driven to the permuter
//   perm_dout      permuter result, valid one cycle after it samples its inputs
//   rsp_valid      response valid
//   rsp_ready      response consumer ready
//   rsp_data       permuted data
//   rsp_id         index of the requester the response belongs to
// -----------------------------------------------------------------------------
module permuter_rr_scheduler #(
  parameter  int SIZE = 4,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*4*SIZE-1:0] req_din,
  input  logic [NREQ*2-1:0]      req_control,
  output logic [4*SIZE-1:0]      perm_din,
  output logic [1:0]             perm_control,
  input  logic [4*SIZE-1:0]      perm_dout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [4*SIZE-1:0]      rsp_data,
  output logic [IDW-1:0]         rsp_id
);

  localparam int DW = 4 * SIZE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [IDW-1:0]  r_ptr;
  logic [DW-1:0]   r_perm_din;
  logic [1:0]      r_perm_ctrl;
  logic [DW-1:0]   r_rsp_data;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_rsp_valid;

  logic            w_gnt_found;
  logic [IDW-1:0]  w_gnt_idx;
  logic [IDW-1:0]  w_cand;
  logic            w_accept;
  logic [DW-1:0]   w_sel_din;
  logic [1:0]      w_sel_ctrl;

  // Round-robin search: first valid requester after the last winner, wrapping.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((32'(r_ptr) + k) % NREQ);
      if (!w_gnt_found && req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  // Gating with rst_n keeps every ready low while reset is held, even though
  // the state register already sits in IDLE.
  assign w_accept  = (r_state == S_IDLE) && rst_n && w_gnt_found;
  assign req_ready = w_accept ? (NREQ'(1) << w_gnt_idx) : '0;

  // Winner's data/control mux.
  always_comb begin
    w_sel_din  = '0;
    w_sel_ctrl = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (32'(w_gnt_idx) == i) begin
        w_sel_din  = req_din[i*DW +: DW];
        w_sel_ctrl = req_control[i*2 +: 2];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_RESP;
      S_RESP:    if (rsp_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers. perm_din/perm_control only load on accept, so they
  // stay stable for the whole transaction and keep their value afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= IDW'(NREQ - 1);
      r_perm_din  <= '0;
      r_perm_ctrl <= '0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_perm_din  <= w_sel_din;
        r_perm_ctrl <= w_sel_ctrl;
        r_rsp_id    <= w_gnt_idx;
        r_ptr       <= w_gnt_idx;
      end
      if (r_state == S_CAPTURE) begin
        r_rsp_data  <= perm_dout;
        r_rsp_valid <= 1'b1;
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign perm_din     = r_perm_din;
  assign perm_control = r_perm_ctrl;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_id       = r_rsp_id;

endmodule

// File: tb/tb_permuter_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_permuter_rr_scheduler
//   Bench for permuter_rr_scheduler with a behavioural 4-lane permuter and a
//   transaction-level reference model (round-robin order, 3-cycle latency,
//   lane permutation computed from lane indices).
// -----------------------------------------------------------------------------
module tb_permuter_rr_scheduler;

  localparam int SIZE = 4;
  localparam int NREQ = 4;
  localparam int IDW  = $clog2(NREQ);
  localparam int DW   = 4 * SIZE;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_din;
  logic [NREQ*2-1:0]    req_control;
  logic [DW-1:0]        perm_din;
  logic [1:0]           perm_control;
  logic [DW-1:0]        perm_dout;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DW-1:0]        rsp_data;
  logic [IDW-1:0]       rsp_id;

  // Requester-side stimulus
  logic [NREQ-1:0]      t_valid;
  logic [DW-1:0]        t_din [NREQ];
  logic [1:0]           t_ctrl[NREQ];
  int                   mode;       // 0: drop on accept, 1: refill on accept, 2: random
  logic [NREQ-1:0]      acc_mask;

  // Reference model
  bit                   m_busy;
  int unsigned          m_acc;
  int                   m_last;
  logic [DW-1:0]        m_din;
  logic [1:0]           m_ctrl;
  bit                   prev_rv;
  int unsigned          cyc;

  int                   acc_log[$];
  int unsigned          rsp_id_q[$];
  logic [DW-1:0]        rsp_data_q[$];
  int unsigned          rsp_cyc_q[$];
  int unsigned          lat_q[$];

  int unsigned          n_checks = 0;
  int unsigned          n_fail   = 0;

  always #5 clk = ~clk;

  assign req_valid = t_valid;
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_din[i*DW +: DW]    = t_din[i];
      req_control[i*2 +: 2]  = t_ctrl[i];
    end
  end

  permuter_rr_scheduler #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_din      (req_din),
    .req_control  (req_control),
    .perm_din     (perm_din),
    .perm_control (perm_control),
    .perm_dout    (perm_dout),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id)
  );

  // Output lane j takes input lane src(j): identity, pair swap, swap pairs, reverse.
  function automatic logic [DW-1:0] permute(input logic [DW-1:0] d, input logic [1:0] c);
    logic [SIZE-1:0] lane[4];
    logic [DW-1:0]   o;
    int              src;
    for (int j = 0; j < 4; j++) lane[j] = d[j*SIZE +: SIZE];
    o = '0;
    for (int j = 0; j < 4; j++) begin
      case (c)
        2'b00:   src = j;
        2'b01:   src = j ^ 1;
        2'b10:   src = j ^ 2;
        default: src = 3 - j;
      endcase
      o[j*SIZE +: SIZE] = lane[src];
    end
    return o;
  endfunction

  // Behavioural registered permuter, one cycle of latency.
  always @(posedge clk) perm_dout <= permute(perm_din, perm_control);

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    ((req_ready & ~req_valid) == '0));
  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Compare DUT outputs against the model, then advance the model by one cycle.
  task automatic sample();
    logic [NREQ-1:0] exp_ready;
    bit              exp_rv;
    int              g;
    exp_ready = '0;
    g         = -1;
    acc_mask  = '0;
    if (!rst_n) begin
      check_eq("rst_req_ready", 64'(req_ready), 64'(0));
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check_eq("rst_rsp_data",  64'(rsp_data),  64'(0));
      check_eq("rst_rsp_id",    64'(rsp_id),    64'(0));
      check_eq("rst_perm_din",  64'(perm_din),  64'(0));
      check_eq("rst_perm_ctrl", 64'(perm_control), 64'(0));
      m_busy  = 1'b0;
      m_last  = NREQ - 1;
      m_din   = '0;
      m_ctrl  = '0;
      prev_rv = 1'b0;
    end else begin
      if (!m_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (g < 0 && t_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
      exp_rv = m_busy && (cyc - m_acc >= 3);
      check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
        check_eq("rsp_data", 64'(rsp_data), 64'(permute(m_din, m_ctrl)));
        check_eq("rsp_id",   64'(rsp_id),   64'(m_last));
      end
      check_eq("perm_din",  64'(perm_din),     64'(m_din));
      check_eq("perm_ctrl", 64'(perm_control), 64'(m_ctrl));
      if (rsp_valid && !prev_rv) lat_q.push_back(cyc - m_acc);
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        rsp_id_q.push_back(32'(rsp_id));
        rsp_data_q.push_back(rsp_data);
        rsp_cyc_q.push_back(cyc);
      end
      if (g >= 0) begin
        acc_mask = exp_ready;
        m_busy   = 1'b1;
        m_acc    = cyc;
        m_last   = g;
        m_din    = t_din[g];
        m_ctrl   = t_ctrl[g];
        acc_log.push_back(g);
      end else if (exp_rv && rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic update_requesters();
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i]) begin
        if (mode == 0) begin
          t_valid[i] = 1'b0;
        end else begin
          t_din[i]  = DW'($urandom);
          t_ctrl[i] = 2'($urandom);
          if (mode == 2 && $urandom_range(0, 99) < 40) t_valid[i] = 1'b0;
        end
      end else if (mode == 2) begin
        if (!t_valid[i] && $urandom_range(0, 99) < 30) begin
          t_valid[i] = 1'b1;
          t_din[i]   = DW'($urandom);
          t_ctrl[i]  = 2'($urandom);
        end else if (t_valid[i] && $urandom_range(0, 99) < 4) begin
          t_valid[i] = 1'b0;  // withdraw before grant
        end
      end
    end
    if (mode == 2) rsp_ready = ($urandom_range(0, 99) < 70);
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
    update_requesters();
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    t_valid = '0;
    mode    = 0;
    acc_log.delete();
    rsp_id_q.delete();
    rsp_data_q.delete();
    rsp_cyc_q.delete();
    lat_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_rsps(input int n, input string tag);
    int b = 0;
    while (rsp_id_q.size() < n && b < 80) begin
      tick();
      b++;
    end
    check_eq(tag, 64'(rsp_id_q.size()), 64'(n));
  endtask

  task automatic drain();
    int b = 0;
    t_valid   = '0;
    rsp_ready = 1'b1;
    mode      = 0;
    while (m_busy && b < 20) begin
      tick();
      b++;
    end
    check_eq("drain_rsp_valid", 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] t2_exp [3];
    logic [1:0]    t2_ctl [3];
    logic [DW-1:0] t4_din;
    logic [1:0]    t4_ctl;
    int            base;
    int            b;

    t2_ctl = '{2'b10, 2'b11, 2'b00};
    t2_exp = '{16'h2143, 16'h1234, 16'h4321};
    cyc       = 0;
    rsp_ready = 1'b1;
    t_valid   = '0;
    acc_mask  = '0;
    for (int i = 0; i < NREQ; i++) begin
      t_din[i]  = '0;
      t_ctrl[i] = '0;
    end

    // 1: requester 0, pair swap
    do_reset();
    t_din[0] = 16'h4321; t_ctrl[0] = 2'b01; t_valid[0] = 1'b1;
    wait_rsps(1, "t1_wait");
    if (rsp_id_q.size() >= 1) begin
      check_eq("t1_data", 64'(rsp_data_q[0]), 64'h3412);
      check_eq("t1_id",   64'(rsp_id_q[0]),   64'(0));
      check_eq("t1_latency", 64'(lat_q[0]),   64'(3));
    end

    // 2: requester 2, controls 10, 11, 00
    for (int k = 0; k < 3; k++) begin
      base = rsp_id_q.size();
      t_din[2] = 16'h4321; t_ctrl[2] = t2_ctl[k]; t_valid[2] = 1'b1;
      wait_rsps(base + 1, "t2_wait");
      if (rsp_id_q.size() > base) begin
        check_eq("t2_data", 64'(rsp_data_q[base]), 64'(t2_exp[k]));
        check_eq("t2_id",   64'(rsp_id_q[base]),   64'(2));
      end
    end

    // 3: all requesters valid from reset
    do_reset();
    mode = 1;
    for (int i = 0; i < NREQ; i++) begin
      t_din[i]  = DW'($urandom);
      t_ctrl[i] = 2'($urandom);
    end
    t_valid = '1;
    wait_rsps(5, "t3_wait");
    if (rsp_id_q.size() >= 5) begin
      for (int k = 0; k < 5; k++) check_eq("t3_rr_id", 64'(rsp_id_q[k]), 64'(k % NREQ));
      for (int k = 0; k < 4; k++)
        check_eq("t3_interval", 64'(rsp_cyc_q[k+1] - rsp_cyc_q[k]), 64'(4));
    end
    drain();

    // 4: response back-pressure for 5 cycles
    base = rsp_id_q.size();
    rsp_ready = 1'b0;
    t4_din = DW'($urandom); t4_ctl = 2'($urandom);
    t_din[3] = t4_din; t_ctrl[3] = t4_ctl; t_valid[3] = 1'b1;
    b = 0;
    while (!rsp_valid && b < 20) begin
      tick();
      b++;
    end
    t_din[0] = DW'($urandom); t_ctrl[0] = 2'($urandom); t_valid[0] = 1'b1;
    repeat (5) begin
      tick();
      check_eq("t4_valid_held", 64'(rsp_valid), 64'(1));
      check_eq("t4_data_held",  64'(rsp_data),  64'(permute(t4_din, t4_ctl)));
      check_eq("t4_id_held",    64'(rsp_id),    64'(3));
      check_eq("t4_no_ready",   64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    wait_rsps(base + 2, "t4_wait");
    if (rsp_id_q.size() >= base + 2) begin
      check_eq("t4_first_id",  64'(rsp_id_q[base]),   64'(3));
      check_eq("t4_resume_id", 64'(rsp_id_q[base+1]), 64'(0));
    end
    drain();

    // 5: reset during CAPTURE; requester 0 wins first afterwards
    base = rsp_id_q.size();
    t_din[1] = DW'($urandom); t_valid[1] = 1'b1;
    wait_rsps(base + 1, "t5_ptr_setup");
    t_din[2] = DW'($urandom); t_ctrl[2] = 2'b11; t_valid[2] = 1'b1;
    b = 0;
    while (!(m_busy && (cyc - m_acc == 2)) && b < 20) begin
      tick();
      b++;
    end
    t_valid = '1;
    rst_n   = 1'b0;
    #1;
    check_eq("t5_rsp_valid_in_reset", 64'(rsp_valid), 64'(0));
    check_eq("t5_ready_in_reset",     64'(req_ready), 64'(0));
    acc_log.delete();
    tick();
    tick();
    rst_n = 1'b1;
    b = 0;
    while (acc_log.size() < 1 && b < 10) begin
      tick();
      b++;
    end
    check_eq("t5_first_grant_count", 64'(acc_log.size()), 64'(1));
    if (acc_log.size() >= 1) check_eq("t5_first_grant", 64'(acc_log[0]), 64'(0));

    // 6: requester 1 withdraws one cycle before its turn
    do_reset();
    t_din[0] = DW'($urandom); t_valid[0] = 1'b1;
    b = 0;
    while (acc_log.size() < 1 && b < 10) begin
      tick();
      b++;
    end
    t_din[1] = DW'($urandom); t_valid[1] = 1'b1;
    t_din[3] = DW'($urandom); t_valid[3] = 1'b1;
    b = 0;
    while ((cyc - m_acc) < 3 && b < 10) begin
      tick();
      b++;
    end
    t_valid[1] = 1'b0;
    b = 0;
    while (acc_log.size() < 2 && b < 10) begin
      tick();
      b++;
    end
    check_eq("t6_grant_count", 64'(acc_log.size()), 64'(2));
    if (acc_log.size() >= 2) check_eq("t6_skip_to_3", 64'(acc_log[1]), 64'(3));
    drain();

    // Randomized traffic against the model
    do_reset();
    mode = 2;
    repeat (1500) tick();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual running expected finished");
    $fatal(1);
  end

endmodule
